// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan capture: segment patterns, FSM states, bus layout.
package seg7_pkg;

  // Active-low segment patterns, bit 6 = a ... bit 0 = g
  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h60;
  localparam logic [6:0] SEG_C     = 7'h31;
  localparam logic [6:0] SEG_D     = 7'h42;
  localparam logic [6:0] SEG_E     = 7'h30;
  localparam logic [6:0] SEG_F     = 7'h38;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int SEG_IDX_A = 6;
  localparam int SEG_IDX_B = 5;
  localparam int SEG_IDX_C = 4;
  localparam int SEG_IDX_D = 3;
  localparam int SEG_IDX_E = 2;
  localparam int SEG_IDX_F = 1;
  localparam int SEG_IDX_G = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;
  } bus_t;

  function automatic logic onehot_low(input logic [3:0] an_n);
    return ($countones(~an_n) == 1);
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Pattern decoder: active-low segments -> {nibble, blank, err}.
// Latency: combinational; no backpressure.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg_n,
  output logic [3:0] o_nibble,
  output logic       o_blank,
  output logic       o_err
);

  always_comb begin
    o_nibble = 4'h0;
    o_blank  = 1'b0;
    o_err    = 1'b0;
    case (i_seg_n)
      SEG_0:     o_nibble = 4'h0;
      SEG_1:     o_nibble = 4'h1;
      SEG_2:     o_nibble = 4'h2;
      SEG_3:     o_nibble = 4'h3;
      SEG_4:     o_nibble = 4'h4;
      SEG_5:     o_nibble = 4'h5;
      SEG_6:     o_nibble = 4'h6;
      SEG_7:     o_nibble = 4'h7;
      SEG_8:     o_nibble = 4'h8;
      SEG_9:     o_nibble = 4'h9;
      SEG_A:     o_nibble = 4'hA;
      SEG_B:     o_nibble = 4'hB;
      SEG_C:     o_nibble = 4'hC;
      SEG_D:     o_nibble = 4'hD;
      SEG_E:     o_nibble = 4'hE;
      SEG_F:     o_nibble = 4'hF;
      SEG_BLANK: o_blank  = 1'b1;
      default:   o_err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Reconstructs a 4-digit hex value from a multiplexed active-low 7-segment bus.
// Latency: digit latched STABLE_CYCLES after first stable input, frame outputs one edge later; monitor only, no backpressure.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [6:0]  i_seg_n,
  input  logic        i_dp_n,
  input  logic [3:0]  i_an_n,
  output logic [15:0] o_value,
  output logic [3:0]  o_dp,
  output logic [3:0]  o_blank,
  output logic [3:0]  o_err,
  output logic        o_frame_valid,
  output logic        o_stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  bus_t          r_sample, r_prev;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_onehot, w_same, w_latch, w_frame_done;
  logic [3:0]    w_nibble;
  logic          w_is_blank, w_is_err;
  logic [15:0]   r_stg_value, r_value;
  logic [3:0]    r_stg_dp, r_stg_blank, r_stg_err, r_seen;
  logic [3:0]    r_dp, r_blank, r_err;
  logic          r_frame_valid, r_stale;
  logic [TW-1:0] r_to_cnt;

  assign w_onehot     = onehot_low(r_sample.an_n);
  assign w_same       = (r_sample == r_prev);
  assign w_frame_done = (r_seen == 4'hF);

  seg7_to_hex u_dec (
    .i_seg_n  (r_sample.seg_n),
    .o_nibble (w_nibble),
    .o_blank  (w_is_blank),
    .o_err    (w_is_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sample <= '0;
      r_prev   <= '0;
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
    end else begin
      r_sample <= {i_an_n, i_seg_n, i_dp_n};
      r_prev   <= r_sample;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_onehot) w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!w_onehot)
          w_state_nxt = ST_IDLE;
        else if (w_same && r_cnt == CW'(STABLE_CYCLES - 1))
          w_state_nxt = ST_HOLD;
      end
      // A change leaving HOLD is evaluated as if from IDLE in the same cycle
      ST_HOLD:   if (!w_same) w_state_nxt = w_onehot ? ST_SETTLE : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_latch   = 1'b0;
    w_cnt_nxt = r_cnt;
    case (r_state)
      ST_IDLE:   w_cnt_nxt = w_onehot ? CW'(1) : CW'(0);
      ST_SETTLE: begin
        if (!w_onehot)
          w_cnt_nxt = CW'(0);
        else if (!w_same)
          w_cnt_nxt = CW'(1);
        else begin
          w_cnt_nxt = r_cnt + CW'(1);
          w_latch   = (r_cnt == CW'(STABLE_CYCLES - 1));
        end
      end
      ST_HOLD:   if (!w_same) w_cnt_nxt = w_onehot ? CW'(1) : CW'(0);
      default:   w_cnt_nxt = CW'(0);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stg_value <= '0;
      r_stg_dp    <= '0;
      r_stg_blank <= '0;
      r_stg_err   <= '0;
      r_seen      <= '0;
    end else begin
      if (w_latch) begin
        for (int i = 0; i < 4; i++) begin
          if (!r_sample.an_n[i]) begin
            r_stg_value[i*4 +: 4] <= w_nibble;
            r_stg_dp[i]           <= ~r_sample.dp_n;
            r_stg_blank[i]        <= w_is_blank;
            r_stg_err[i]          <= w_is_err;
          end
        end
      end
      // A latch implies a one-hot-low anode, so ~an_n is the digit mask
      r_seen <= (w_frame_done ? 4'h0 : r_seen) | (w_latch ? ~r_sample.an_n : 4'h0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_value       <= '0;
      r_dp          <= '0;
      r_blank       <= 4'hF;
      r_err         <= '0;
      r_frame_valid <= 1'b0;
      r_stale       <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_frame_valid <= w_frame_done;
      if (w_frame_done) begin
        r_value  <= r_stg_value;
        r_dp     <= r_stg_dp;
        r_blank  <= r_stg_blank;
        r_err    <= r_stg_err;
        r_to_cnt <= '0;
        r_stale  <= 1'b0;
      end else if (r_to_cnt != TW'(TIMEOUT_CYCLES)) begin
        r_to_cnt <= r_to_cnt + TW'(1);
        if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) r_stale <= 1'b1;
      end
    end
  end

  assign o_value       = r_value;
  assign o_dp          = r_dp;
  assign o_blank       = r_blank;
  assign o_err         = r_err;
  assign o_frame_valid = r_frame_valid;
  assign o_stale       = r_stale;

endmodule
